float_clamp_vec: RTL and testbench
==================================

FLOAT_CLAMP_VEC -- requirements
Module: float_clamp_vec

Interface
REQ-001 SHALL have parameter SIZE, default 64: float width; legal values 32 (single) and 64 (double).
REQ-002 SHALL have parameter CHANNELS, default 3: independent lanes per beat; legal range 1..8.
REQ-003 SHALL have parameter LO, default +0.0 in SIZE format: lower bound bit pattern.
REQ-004 SHALL have parameter HI, default 255.0 in SIZE format (64'h406FE00000000000 / 32'h437F0000): upper bound bit pattern; LO <= HI numerically.
REQ-005 SHALL have the following ports, one per line (clock and reset first):
  aclk  in  1  sole clock; all logic on rising edge
  aresetn  in  1  reset, asynchronous, active-low
  s_axis_tdata  in  CHANNELS*SIZE  input lanes; lane i at bits [i*SIZE +: SIZE]
  s_axis_tvalid  in  1  input beat valid
  s_axis_tready  out  1  input beat accepted when tvalid && tready
  m_axis_tdata  out  CHANNELS*SIZE  clamped lanes; same lane packing
  m_axis_tvalid  out  1  output beat valid
  m_axis_tready  in  1  downstream accepts
  stats_clear  in  1  synchronous clear of statistics (present only with REQ-019)
  clamp_lo_count  out  32  lanes clamped to LO (present only with REQ-019)
  clamp_hi_count  out  32  lanes clamped to HI (present only with REQ-019)

Function
REQ-006 SHALL compare natively on IEEE bit patterns (sign-magnitude ordering key), with no floating-point IP core.
REQ-007 SHALL output, per lane: LO if x < LO; HI if x > HI; x unchanged otherwise.
REQ-008 SHALL order -0.0 below +0.0; with default LO, -0.0 -> +0.0 (all-zero pattern).
REQ-009 SHALL map any NaN (exponent all ones, mantissa nonzero, either sign) to LO and count it as a low clamp.
REQ-010 SHALL clamp -inf to LO and +inf to HI; subnormals compare by value.
REQ-011 SHALL be a 2-stage pipeline: stage 1 registers lane data plus below/above/NaN flags; stage 2 registers the selected result; latency exactly 2 cycles with no stalls.
REQ-012 SHALL sustain one beat per cycle while m_axis_tready stays high.
REQ-013 SHALL advance stage 2 when !v2 || m_axis_tready, and stage 1 when !v1 || stage-2 advance; s_axis_tready equals the stage-1 advance condition.
REQ-014 SHALL hold m_axis_tdata and m_axis_tvalid stable while m_axis_tvalid && !m_axis_tready.
REQ-015 SHALL never drop or duplicate a beat; with both stages full and m_axis_tready low, s_axis_tready is low.
REQ-016 SHALL keep lanes independent: one lane's clamp never affects another lane.

Reset
REQ-017 SHALL, on aresetn low, immediately clear v1, v2, m_axis_tvalid, m_axis_tdata (to 0), clamp_lo_count and clamp_hi_count; in-flight beats are discarded.
REQ-018 SHALL drive s_axis_tready high during and after reset (both stages empty) and ignore s_axis_tvalid while aresetn is low; first beat is accepted on the first rising edge with aresetn high.

Configuration
REQ-019 SHALL include the statistics ports and counters only when macro FLOAT_CLAMP_STATS_EN is defined; without it, those ports and all counter logic are absent, and the datapath and timing are identical.
REQ-020 SHALL, with FLOAT_CLAMP_STATS_EN, add per output handshake (m_axis_tvalid && m_axis_tready) the number of lanes clamped low / high to the respective counter, saturating at 32'hFFFFFFFF.
REQ-021 SHALL give stats_clear priority: counters go to 0 on that edge and that cycle's increments are dropped.

Verification
REQ-022 SHALL pass: SIZE=64, CHANNELS=3, lanes {-5.0, 128.0, 300.0} with m_axis_tready high -> {+0.0, 128.0, 255.0} exactly 2 cycles later; lo_count=1, hi_count=1.
REQ-023 SHALL pass: lanes {NaN 64'h7FF8000000000000, -0.0, +inf} -> {0, 0, 64'h406FE00000000000}; lo_count+=2, hi_count+=1.
REQ-024 SHALL pass: 10 back-to-back beats, m_axis_tready low for cycles 3-6 -> data held stable, s_axis_tready low once both stages are full, all 10 beats out in order, none lost or duplicated.
REQ-025 SHALL pass: aresetn pulsed low with 2 beats in flight -> m_axis_tvalid 0 immediately, counters 0, neither beat emerges after release.
REQ-026 SHALL pass: SIZE=32, LO=1.0 (32'h3F800000), HI=2.0 (32'h40000000), input 0.5/1.5/2.5 -> 1.0/1.5/2.0; stats_clear asserted in the same cycle as a clamping handshake -> counters read 0.

Source files
------------

// File: rtl/float_clamp_vec.sv
// float_clamp_vec: clamps CHANNELS IEEE-754 lanes (SIZE = 32 or 64) to [LO, HI]
// in a 2-stage AXI-Stream pipeline. Comparison uses a sign-magnitude ordering key,
// so no floating-point core is needed. NaN maps to LO, -0.0 orders below +0.0.
// Optional lane-clamp statistics are built only when FLOAT_CLAMP_STATS_EN is defined.
module float_clamp_vec #(
    parameter int              SIZE     = 64,
    parameter int              CHANNELS = 3,
    parameter logic [SIZE-1:0] LO       = '0,
    parameter logic [SIZE-1:0] HI       = (SIZE == 64) ? SIZE'(64'h406F_E000_0000_0000)
                                                       : SIZE'(32'h437F_0000)
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic [CHANNELS*SIZE-1:0] s_axis_tdata,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    output logic [CHANNELS*SIZE-1:0] m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready
`ifdef FLOAT_CLAMP_STATS_EN
    ,
    input  logic                     stats_clear,
    output logic [31:0]              clamp_lo_count,
    output logic [31:0]              clamp_hi_count
`endif
);

    localparam int EXP_W = (SIZE == 64) ? 11 : 8;
    localparam int MAN_W = SIZE - 1 - EXP_W;
    localparam int W     = CHANNELS * SIZE;

    // Map an IEEE pattern to an unsigned key whose order matches numeric order:
    // negatives are bit-inverted, positives get the sign bit set.
    function automatic logic [SIZE-1:0] order_key(input logic [SIZE-1:0] x);
        return x[SIZE-1] ? ~x : {1'b1, x[SIZE-2:0]};
    endfunction

    localparam logic [SIZE-1:0] LO_KEY = order_key(LO);
    localparam logic [SIZE-1:0] HI_KEY = order_key(HI);

    logic                v1, v2;
    logic                adv1, adv2;
    logic [W-1:0]        d1;
    logic [CHANNELS-1:0] below1, above1, nan1;
    logic [CHANNELS-1:0] below_c, above_c, nan_c;
    logic [W-1:0]        sel_data;

    assign adv2          = !v2 || m_axis_tready;
    assign adv1          = !v1 || adv2;
    assign s_axis_tready = adv1;
    assign m_axis_tvalid = v2;

    // Per-lane compare against the bounds and NaN detection for the incoming beat.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        below_c = '0;
        above_c = '0;
        nan_c   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            below_c[i] = order_key(s_axis_tdata[i*SIZE +: SIZE]) < LO_KEY;
            above_c[i] = order_key(s_axis_tdata[i*SIZE +: SIZE]) > HI_KEY;
            nan_c[i]   = (&s_axis_tdata[i*SIZE + MAN_W +: EXP_W])
                         && (|s_axis_tdata[i*SIZE +: MAN_W]);
        end
    end

    // Stage 1: capture lane data and its compare flags whenever the stage can advance.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
            v1     <= 1'b0;
            d1     <= '0;
            below1 <= '0;
            above1 <= '0;
            nan1   <= '0;
        end else if (adv1) begin
            v1     <= s_axis_tvalid;
            d1     <= s_axis_tdata;
            below1 <= below_c;
            above1 <= above_c;
            nan1   <= nan_c;
        end
    end

    // Select LO, HI or the original lane; NaN takes priority and goes to LO.
    always_comb begin
        sel_data = d1;
        for (int i = 0; i < CHANNELS; i++) begin
            if (nan1[i] || below1[i]) begin
                sel_data[i*SIZE +: SIZE] = LO;
            end else if (above1[i]) begin
                sel_data[i*SIZE +: SIZE] = HI;
            end
        end
    end

    // Stage 2: output register, held while the downstream stalls.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            // NOTE: the datapath registers are reset too, because the output data must read 0 in reset.
            v2           <= 1'b0;
            m_axis_tdata <= '0;
        end else if (adv2) begin
            v2           <= v1;
            m_axis_tdata <= sel_data;
        end
    end

`ifdef FLOAT_CLAMP_STATS_EN
    logic [CHANNELS-1:0] lo_c, hi_c;
    logic [CHANNELS-1:0] lo2, hi2;
    logic [3:0]          lo_n, hi_n;

    function automatic logic [31:0] sat_add(input logic [31:0] c, input logic [3:0] n);
        logic [32:0] s;
        s = {1'b0, c} + {29'd0, n};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    // Which lanes of the stage-1 beat are clamped low (incl. NaN) or high.
    always_comb begin
        lo_c = nan1 | below1;
        hi_c = above1 & ~nan1;
    end

    // Clamp flags travel alongside the stage-2 data.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            lo2 <= '0;
            hi2 <= '0;
        end else if (adv2) begin
            lo2 <= lo_c;
            hi2 <= hi_c;
        end
    end

    // Count clamped lanes in the beat currently on the output.
    always_comb begin
        lo_n = '0;
        hi_n = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            lo_n = lo_n + {3'd0, lo2[i]};
            hi_n = hi_n + {3'd0, hi2[i]};
        end
    end

    // Saturating counters, advanced on each output handshake; clear wins over increment.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            clamp_lo_count <= '0;
            clamp_hi_count <= '0;
        end else if (stats_clear) begin
            clamp_lo_count <= '0;
            clamp_hi_count <= '0;
        end else if (v2 && m_axis_tready) begin
            clamp_lo_count <= sat_add(clamp_lo_count, lo_n);
            clamp_hi_count <= sat_add(clamp_hi_count, hi_n);
        end
    end
`endif

endmodule

// File: tb/tb_float_clamp_vec.sv
// Testbench for float_clamp_vec: a double-precision instance with default bounds
// and a single-precision instance clamping to [1.0, 2.0]. Expected beats are queued
// at acceptance and compared by independent output monitors.
`timescale 1ns/1ps
module tb_float_clamp_vec;

    localparam logic [63:0] D_NEG5  = 64'hC014_0000_0000_0000;
    localparam logic [63:0] D_128   = 64'h4060_0000_0000_0000;
    localparam logic [63:0] D_300   = 64'h4072_C000_0000_0000;
    localparam logic [63:0] D_255   = 64'h406F_E000_0000_0000;
    localparam logic [63:0] D_255P  = 64'h406F_E000_0000_0001;
    localparam logic [63:0] D_NAN   = 64'h7FF8_0000_0000_0000;
    localparam logic [63:0] D_NNAN  = 64'hFFF8_0000_0000_0001;
    localparam logic [63:0] D_NZERO = 64'h8000_0000_0000_0000;
    localparam logic [63:0] D_PINF  = 64'h7FF0_0000_0000_0000;
    localparam logic [63:0] D_NINF  = 64'hFFF0_0000_0000_0000;
    localparam logic [63:0] D_SUB   = 64'h0000_0000_0000_0001;
    localparam logic [63:0] D_ZERO  = 64'h0;

    localparam logic [31:0] F_0P5  = 32'h3F00_0000;
    localparam logic [31:0] F_1P0  = 32'h3F80_0000;
    localparam logic [31:0] F_1P5  = 32'h3FC0_0000;
    localparam logic [31:0] F_2P0  = 32'h4000_0000;
    localparam logic [31:0] F_2P5  = 32'h4020_0000;
    localparam logic [31:0] F_NAN  = 32'h7FC0_0000;
    localparam logic [31:0] F_NINF = 32'hFF80_0000;
    localparam logic [31:0] F_PINF = 32'h7F80_0000;

    logic aclk = 1'b0;
    logic aresetn;
    always #5 aclk = ~aclk;

    logic [191:0] a_s_tdata, a_m_tdata;
    logic         a_s_tvalid, a_s_tready, a_m_tvalid, a_m_tready;
    logic [95:0]  b_s_tdata, b_m_tdata;
    logic         b_s_tvalid, b_s_tready, b_m_tvalid, b_m_tready;
`ifdef FLOAT_CLAMP_STATS_EN
    logic         a_stats_clear, b_stats_clear;
    logic [31:0]  a_lo_cnt, a_hi_cnt, b_lo_cnt, b_hi_cnt;
`endif

    int checks = 0;
    int errors = 0;
    logic [191:0] exp_a[$];
    logic [95:0]  exp_b[$];

    float_clamp_vec dut_a (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (a_s_tdata),
        .s_axis_tvalid (a_s_tvalid),
        .s_axis_tready (a_s_tready),
        .m_axis_tdata  (a_m_tdata),
        .m_axis_tvalid (a_m_tvalid),
        .m_axis_tready (a_m_tready)
`ifdef FLOAT_CLAMP_STATS_EN
        ,
        .stats_clear    (a_stats_clear),
        .clamp_lo_count (a_lo_cnt),
        .clamp_hi_count (a_hi_cnt)
`endif
    );

    float_clamp_vec #(
        .SIZE     (32),
        .CHANNELS (3),
        .LO       (32'h3F80_0000),
        .HI       (32'h4000_0000)
    ) dut_b (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (b_s_tdata),
        .s_axis_tvalid (b_s_tvalid),
        .s_axis_tready (b_s_tready),
        .m_axis_tdata  (b_m_tdata),
        .m_axis_tvalid (b_m_tvalid),
        .m_axis_tready (b_m_tready)
`ifdef FLOAT_CLAMP_STATS_EN
        ,
        .stats_clear    (b_stats_clear),
        .clamp_lo_count (b_lo_cnt),
        .clamp_hi_count (b_hi_cnt)
`endif
    );

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    function automatic logic [191:0] p64(input logic [63:0] l0, input logic [63:0] l1,
                                         input logic [63:0] l2);
        return {l2, l1, l0};
    endfunction

    function automatic logic [95:0] p32(input logic [31:0] l0, input logic [31:0] l1,
                                        input logic [31:0] l2);
        return {l2, l1, l0};
    endfunction

    // Output monitor / scoreboard for the double-precision instance.
    logic         a_hold_prev = 1'b0;
    logic [191:0] a_prev_data;
    always @(negedge aclk) begin
        if (aresetn) begin
            if (a_hold_prev) begin
                check("a_hold_valid", {191'd0, a_m_tvalid}, 192'd1);
                check("a_hold_data", a_m_tdata, a_prev_data);
            end
            if (a_m_tvalid && a_m_tready) begin
                if (exp_a.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL a_unexpected_beat: got %h, required no beat", a_m_tdata);
                end else begin
                    check("a_beat", a_m_tdata, exp_a.pop_front());
                end
            end
            a_hold_prev = a_m_tvalid && !a_m_tready;
            a_prev_data = a_m_tdata;
        end else begin
            a_hold_prev = 1'b0;
        end
    end

    // Output monitor / scoreboard for the single-precision instance.
    logic        b_hold_prev = 1'b0;
    logic [95:0] b_prev_data;
    always @(negedge aclk) begin
        if (aresetn) begin
            if (b_hold_prev) begin
                check("b_hold_valid", {191'd0, b_m_tvalid}, 192'd1);
                check("b_hold_data", {96'd0, b_m_tdata}, {96'd0, b_prev_data});
            end
            if (b_m_tvalid && b_m_tready) begin
                if (exp_b.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b_unexpected_beat: got %h, required no beat", b_m_tdata);
                end else begin
                    check("b_beat", {96'd0, b_m_tdata}, {96'd0, exp_b.pop_front()});
                end
            end
            b_hold_prev = b_m_tvalid && !b_m_tready;
            b_prev_data = b_m_tdata;
        end else begin
            b_hold_prev = 1'b0;
        end
    end

    // Present one beat, wait (bounded) for acceptance, queue its expected result.
    task automatic drive_a(input logic [191:0] d, input logic [191:0] e);
        int waited = 0;
        a_s_tdata  = d;
        a_s_tvalid = 1'b1;
        @(negedge aclk);
        while (!a_s_tready && waited < 50) begin
            waited++;
            @(negedge aclk);
        end
        if (!a_s_tready) begin
            checks++;
            errors++;
            $display("FAIL a_accept_timeout: tready low for %0d cycles, required accept", waited);
        end else begin
            exp_a.push_back(e);
        end
        @(posedge aclk);
        #1;
        a_s_tvalid = 1'b0;
    endtask

    task automatic drive_b(input logic [95:0] d, input logic [95:0] e);
        int waited = 0;
        b_s_tdata  = d;
        b_s_tvalid = 1'b1;
        @(negedge aclk);
        while (!b_s_tready && waited < 50) begin
            waited++;
            @(negedge aclk);
        end
        if (!b_s_tready) begin
            checks++;
            errors++;
            $display("FAIL b_accept_timeout: tready low for %0d cycles, required accept", waited);
        end else begin
            exp_b.push_back(e);
        end
        @(posedge aclk);
        #1;
        b_s_tvalid = 1'b0;
    endtask

    task automatic drain_a();
        int n = 0;
        while (exp_a.size() != 0 && n < 100) begin
            @(negedge aclk);
            n++;
        end
        if (exp_a.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL a_drain_timeout: %0d beats outstanding, required 0", exp_a.size());
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic drain_b();
        int n = 0;
        while (exp_b.size() != 0 && n < 100) begin
            @(negedge aclk);
            n++;
        end
        if (exp_b.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL b_drain_timeout: %0d beats outstanding, required 0", exp_b.size());
        end
        @(posedge aclk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        aresetn    = 1'b0;
        a_s_tdata  = '0;
        a_s_tvalid = 1'b1;
        a_m_tready = 1'b1;
        b_s_tdata  = '0;
        b_s_tvalid = 1'b0;
        b_m_tready = 1'b1;
`ifdef FLOAT_CLAMP_STATS_EN
        a_stats_clear = 1'b0;
        b_stats_clear = 1'b0;
`endif

        // Reset state; tvalid is high on A throughout reset and must be ignored.
        repeat (2) @(negedge aclk);
        check("rst_a_tvalid", {191'd0, a_m_tvalid}, 192'd0);
        check("rst_a_tdata", a_m_tdata, 192'd0);
        check("rst_a_tready", {191'd0, a_s_tready}, 192'd1);
        check("rst_b_tready", {191'd0, b_s_tready}, 192'd1);
        check("rst_b_tvalid", {191'd0, b_m_tvalid}, 192'd0);
`ifdef FLOAT_CLAMP_STATS_EN
        check("rst_a_lo_cnt", {160'd0, a_lo_cnt}, 192'd0);
        check("rst_a_hi_cnt", {160'd0, a_hi_cnt}, 192'd0);
`endif
        @(posedge aclk);
        #1;
        a_s_tvalid = 1'b0;
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        check("rel_a_tready", {191'd0, a_s_tready}, 192'd1);

        // Basic clamp with 2-cycle latency check.
        drive_a(p64(D_NEG5, D_128, D_300), p64(D_ZERO, D_128, D_255));
        @(negedge aclk);
        check("lat_a_not_yet", {191'd0, a_m_tvalid}, 192'd0);
        @(negedge aclk);
        check("lat_a_valid", {191'd0, a_m_tvalid}, 192'd1);
        drain_a();
`ifdef FLOAT_CLAMP_STATS_EN
        check("t1_lo_cnt", {160'd0, a_lo_cnt}, 192'd1);
        check("t1_hi_cnt", {160'd0, a_hi_cnt}, 192'd1);
`endif

        // NaN, negative zero, +inf.
        drive_a(p64(D_NAN, D_NZERO, D_PINF), p64(D_ZERO, D_ZERO, D_255));
        drain_a();
`ifdef FLOAT_CLAMP_STATS_EN
        check("t2_lo_cnt", {160'd0, a_lo_cnt}, 192'd3);
        check("t2_hi_cnt", {160'd0, a_hi_cnt}, 192'd2);
`endif

        // Boundaries: -inf, exactly HI, one ulp above HI, subnormal, negative NaN, exactly LO.
        drive_a(p64(D_NINF, D_255, D_255P), p64(D_ZERO, D_255, D_255));
        drive_a(p64(D_SUB, D_NNAN, D_ZERO), p64(D_SUB, D_ZERO, D_ZERO));
        drain_a();
`ifdef FLOAT_CLAMP_STATS_EN
        check("t3_lo_cnt", {160'd0, a_lo_cnt}, 192'd5);
        check("t3_hi_cnt", {160'd0, a_hi_cnt}, 192'd3);
`endif

        // Ten back-to-back beats with downstream stalled for four cycles.
        fork
            begin
                for (int k = 0; k < 10; k++) begin
                    drive_a(p64($realtobits(40.0 * k), $realtobits(-1.0 - k), $realtobits(0.5 * k)),
                            p64((k * 40 <= 255) ? $realtobits(40.0 * k) : D_255,
                                D_ZERO, $realtobits(0.5 * k)));
                end
            end
            begin
                repeat (3) @(posedge aclk);
                #1;
                a_m_tready = 1'b0;
                @(negedge aclk);
                check("stall_a_tready_low", {191'd0, a_s_tready}, 192'd0);
                check("stall_a_tvalid", {191'd0, a_m_tvalid}, 192'd1);
                repeat (4) @(posedge aclk);
                #1;
                a_m_tready = 1'b1;
            end
        join
        drain_a();
`ifdef FLOAT_CLAMP_STATS_EN
        check("t4_lo_cnt", {160'd0, a_lo_cnt}, 192'd15);
        check("t4_hi_cnt", {160'd0, a_hi_cnt}, 192'd6);
`endif

        // Reset with two beats in flight: both must be discarded.
        a_m_tready = 1'b0;
        drive_a(p64(D_NEG5, D_128, D_300), p64(D_ZERO, D_128, D_255));
        drive_a(p64(D_128, D_128, D_128), p64(D_128, D_128, D_128));
        aresetn = 1'b0;
        #1;
        check("flight_a_tvalid", {191'd0, a_m_tvalid}, 192'd0);
        check("flight_a_tdata", a_m_tdata, 192'd0);
        check("flight_a_tready", {191'd0, a_s_tready}, 192'd1);
`ifdef FLOAT_CLAMP_STATS_EN
        check("flight_lo_cnt", {160'd0, a_lo_cnt}, 192'd0);
        check("flight_hi_cnt", {160'd0, a_hi_cnt}, 192'd0);
`endif
        exp_a.delete();
        @(posedge aclk);
        #1;
        aresetn    = 1'b1;
        a_m_tready = 1'b1;
        repeat (6) @(negedge aclk);
        check("flight_no_ghost", {191'd0, a_m_tvalid}, 192'd0);
        @(posedge aclk);
        #1;

        // Single precision, bounds [1.0, 2.0].
        drive_b(p32(F_0P5, F_1P5, F_2P5), p32(F_1P0, F_1P5, F_2P0));
        drive_b(p32(F_NAN, F_NINF, F_PINF), p32(F_1P0, F_1P0, F_2P0));
        drain_b();
`ifdef FLOAT_CLAMP_STATS_EN
        check("b_lo_cnt", {160'd0, b_lo_cnt}, 192'd3);
        check("b_hi_cnt", {160'd0, b_hi_cnt}, 192'd2);
`endif

        // Clear coinciding with a clamping handshake: counters end at zero.
        b_m_tready = 1'b0;
        drive_b(p32(F_0P5, F_2P5, F_1P0), p32(F_1P0, F_2P0, F_1P0));
        begin
            int n = 0;
            while (!b_m_tvalid && n < 20) begin
                @(negedge aclk);
                n++;
            end
            check("b_clear_beat_ready", {191'd0, b_m_tvalid}, 192'd1);
        end
        @(posedge aclk);
        #1;
`ifdef FLOAT_CLAMP_STATS_EN
        b_stats_clear = 1'b1;
`endif
        b_m_tready = 1'b1;
        @(posedge aclk);
        #1;
`ifdef FLOAT_CLAMP_STATS_EN
        b_stats_clear = 1'b0;
`endif
        @(negedge aclk);
`ifdef FLOAT_CLAMP_STATS_EN
        check("b_clear_lo_cnt", {160'd0, b_lo_cnt}, 192'd0);
        check("b_clear_hi_cnt", {160'd0, b_hi_cnt}, 192'd0);
`endif
        drain_b();
        drain_a();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
